// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2
    } loader_state_t;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] TERM_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_byte_packer.sv
// Rising-edge byte capture and little-endian 4-byte word assembly.
// Optional inter-byte timeout flush when LOADER_TIMEOUT_EN is defined.
module uart_byte_packer
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                collect,
    input  logic                rx_valid,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_break,
    output logic                word_valid,
    output logic [WORD_W-1:0]   word
);

    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("uart_byte_packer: TIMEOUT_CYCLES must be nonzero");
    end

    logic               valid_q;
    logic [1:0]         cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               take_c;
    logic               discard_c;
    logic               timeout_c;

    assign take_c    = rx_valid & ~valid_q & enable;
    assign discard_c = (rx_break & collect) | timeout_c;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q;

    // A byte arriving on the expiry cycle wins over the flush.
    assign timeout_c = collect && (cnt_q != 2'd0) && !take_c &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else if (take_c || discard_c || (cnt_q == 2'd0)) begin
            idle_q <= '0;
        end else if (collect) begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Bytes enter at the top so the first byte ends up in the low lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            valid_q <= rx_valid;
            if (discard_c) begin
                cnt_q <= 2'd0;
            end else if (take_c) begin
                cnt_q   <= cnt_q + 2'd1;
                shift_q <= {rx_data, shift_q[SHIFT_W-1:BYTE_W]};
            end
        end
    end

    assign word_valid = take_c & ~discard_c & (cnt_q == 2'd3);
    assign word       = {rx_data, shift_q};

endmodule

// File: rtl/uart_imem_loader.sv
// Loads 32-bit instruction words received over UART into instruction memory.
// Define LOADER_TIMEOUT_EN to flush stale partial words after TIMEOUT_CYCLES idle.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned        ADDR_W         = 8,
    parameter logic [WORD_W-1:0]  TERM_WORD      = TERM_WORD_DEFAULT,
    parameter int unsigned        TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rx_valid,
    input  logic [BYTE_W-1:0]   uart_rx_data,
    input  logic                uart_rx_break,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic                write_done,
    output logic                overflow,
    output logic                cpu_rst
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    loader_state_t     state_q, state_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [WORD_W-1:0] wdata_d;
    logic              done_d;
    logic              ovf_d;
    logic              cpu_rst_d;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    uart_byte_packer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .enable     (state_q != DONE),
        .collect    (state_q == COLLECT),
        .rx_valid   (uart_rx_valid),
        .rx_data    (uart_rx_data),
        .rx_break   (uart_rx_break),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            write_done <= 1'b0;
            overflow   <= 1'b0;
            cpu_rst    <= 1'b1;
        end else begin
            state_q    <= state_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            write_done <= done_d;
            overflow   <= ovf_d;
            cpu_rst    <= cpu_rst_d;
        end
    end

    // The write strobe is raised on entry to WRITE so it lines up with that state.
    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        addr_d    = imem_addr;
        wdata_d   = imem_wdata;
        done_d    = write_done;
        ovf_d     = overflow;
        cpu_rst_d = cpu_rst;
        unique case (state_q)
            COLLECT: begin
                if (word_valid) begin
                    state_d = WRITE;
                    wdata_d = word;
                    we_d    = (word != TERM_WORD);
                end
            end
            WRITE: begin
                if (imem_wdata == TERM_WORD) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                end else if (imem_addr == ADDR_LAST) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    ovf_d     = 1'b1;
                    cpu_rst_d = 1'b0;
                end else begin
                    state_d = COLLECT;
                    addr_d  = imem_addr + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

endmodule
